// File: rtl/score_disp_pkg.sv
// Shared types, segment constants and elaboration-time helpers for the
// score display driver.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_e;

    // Segment vectors are {g, f, e, d, c, b, a}.
    localparam logic [6:0] SEG_OFF  = 7'b000_0000;
    localparam logic [6:0] SEG_DASH = 7'b100_0000;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Smallest digit count d with 10^d >= 2^w, i.e. enough digits for 2^w-1.
    function automatic int unsigned bcd_digits_for(input int unsigned w);
        int unsigned d;
        d = 1;
        while (pow10(d) < (64'd1 << w)) begin
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/Led7Seg.sv
// BCD nibble to 7-segment decoder, active-high, bit 0 = segment a.
module Led7Seg (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b000_0000;
        case (i_bcd)
            4'd0:    o_seg = 7'b011_1111;
            4'd1:    o_seg = 7'b000_0110;
            4'd2:    o_seg = 7'b101_1011;
            4'd3:    o_seg = 7'b100_1111;
            4'd4:    o_seg = 7'b110_0110;
            4'd5:    o_seg = 7'b110_1101;
            4'd6:    o_seg = 7'b111_1101;
            4'd7:    o_seg = 7'b000_0111;
            4'd8:    o_seg = 7'b111_1111;
            4'd9:    o_seg = 7'b110_1111;
            default: o_seg = 7'b000_0000;
        endcase
    end

endmodule

// File: rtl/score_bcd_display.sv
// Iterative double-dabble binary-to-BCD converter driving a registered,
// blanked, overflow-aware 7-segment display.
module score_bcd_display
    import score_disp_pkg::*;
#(
    parameter int unsigned W          = 11,
    parameter int unsigned DIGITS     = 3,
    parameter bit          BLANK_LZ   = 1'b1,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          point,
    output logic                  ready,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int unsigned          BD    = bcd_digits_for(W);
    localparam logic [63:0]          LIMIT = pow10(DIGITS);
    localparam int unsigned          CW    = $clog2(W + 1);
    localparam logic [CW-1:0]        LAST  = CW'(W - 1);
    localparam logic [7*DIGITS-1:0]  INV   = {(7 * DIGITS){ACTIVE_LOW}};

    state_e                r_state;
    logic [W-1:0]          r_bin;
    logic [W-1:0]          r_val;
    logic [4*BD-1:0]       r_work;
    logic [CW-1:0]         r_cnt;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_ovf;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [7*DIGITS-1:0]   r_seg;

    logic [4*BD-1:0]       w_adj;
    logic [4*BD-1:0]       w_work_nxt;
    logic [4*DIGITS-1:0]   w_dig;
    logic [7*DIGITS-1:0]   w_dec;
    logic [7*DIGITS-1:0]   w_seg;
    logic                  w_ovf;

    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < int'(BD); i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_work_nxt = {w_adj[4*BD-2:0], r_bin[W-1]};
    assign w_ovf      = 64'(r_val) >= LIMIT;

    // Displayed digits come from the post-shift value so they are ready on the final shift edge.
    if (BD >= DIGITS) begin : g_trunc
        assign w_dig = w_work_nxt[4*DIGITS-1:0];
    end else begin : g_pad
        assign w_dig = {{(4 * (DIGITS - BD)){1'b0}}, w_work_nxt};
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dig
        Led7Seg u_led (
            .i_bcd (w_dig[4*g +: 4]),
            .o_seg (w_dec[7*g +: 7])
        );
    end

    always_comb begin
        logic v_any;
        v_any = 1'b0;
        w_seg = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            v_any = v_any | (|w_dig[4*i +: 4]);
            if (w_ovf) begin
                w_seg[7*i +: 7] = SEG_DASH;
            end else if (BLANK_LZ && (i != 0) && !v_any) begin
                w_seg[7*i +: 7] = SEG_OFF;
            end else begin
                w_seg[7*i +: 7] = w_dec[7*i +: 7];
            end
        end
        w_seg = w_seg ^ INV;
    end

    // Display registers are written on the edge entering LOAD so done and data coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_val   <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_bcd   <= '0;
            r_seg   <= INV;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= point;
                        r_val   <= point;
                        r_work  <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_work_nxt;
                    r_bin  <= r_bin << 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_bcd   <= w_dig;
                        r_seg   <= w_seg;
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign bcd      = r_bcd;
    assign seg      = r_seg;

endmodule
